// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if: word handshake between the CPU side and the UART transmitter.
//   data_i        word to send (driven by master)
//   data_valid_i  request to send data_i (driven by master)
//   ready_o       transmitter holding register empty (driven by slave)
// A transfer happens on a clock edge where data_valid_i && ready_o.
// -----------------------------------------------------------------------------
interface uart_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_i;
  logic              data_valid_i;
  logic              ready_o;

  modport master (output data_i, output data_valid_i, input ready_o);
  modport slave  (input data_i, input data_valid_i, output ready_o);
endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx: UART transmitter. Accepts words over a valid/ready handshake into a
// one-entry holding register and shifts them out as start/data(LSB first)/stop
// frames, back-to-back when the next word is already queued.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after the MSB of every frame.
//
// Ports:
//   clk_i        single clock
//   reset_i      synchronous, active-high reset
//   bus_if       slave side of uart_tx_if (data_i, data_valid_i, ready_o)
//   tx_o         serial line, idle high, registered
//   busy_o       frame in progress or word pending in the holding register
//   done_strb_o  one-cycle pulse on the last cycle of each stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned UART_DATA_LENGTH           = 8,
  parameter int unsigned TX_COUNTER_BITWIDTH        = 3,
  parameter int unsigned BAUD_COUNTS_PER_BIT        = 521,
  parameter int unsigned BAUD_RATE_COUNTER_BITWIDTH = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  uart_tx_if.slave   bus_if,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_strb_o
);

  localparam int unsigned DW = UART_DATA_LENGTH;
  localparam int unsigned IW = TX_COUNTER_BITWIDTH;
  localparam int unsigned BW = BAUD_RATE_COUNTER_BITWIDTH;

  typedef enum logic [2:0] {
    stIDLE,
    stSTARTBIT,
    stSENDING,
`ifdef UART_TX_PARITY_EN
    stPARITY,
`endif
    stSTOPBIT
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic bit_end;
  assign bit_end = (baud_q == BW'(BAUD_COUNTS_PER_BIT));

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= stIDLE;
      baud_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Next-state, handshake and line-level logic. tx and done are derived from
  // the current state so the line lags the FSM by exactly one cycle throughout.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = 1'b1;
    done_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    // Accept only into an empty holding register; a load below only happens
    // when it is full, so the two never collide.
    if (bus_if.data_valid_i && !hold_full_q) begin
      hold_d      = bus_if.data_i;
      hold_full_d = 1'b1;
    end

    if (state_q == stIDLE || bit_end) baud_d = '0;
    else                              baud_d = baud_q + BW'(1);

    unique case (state_q)
      stIDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          idx_d       = '0;
`ifdef UART_TX_PARITY_EN
          par_d       = 1'b0;
`endif
          state_d     = stSTARTBIT;
        end
      end
      stSTARTBIT: begin
        tx_d = 1'b0;
        if (bit_end) begin
          idx_d   = '0;
          state_d = stSENDING;
        end
      end
      stSENDING: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IW'(1);
`ifdef UART_TX_PARITY_EN
          par_d   = par_q ^ shift_q[0];
`endif
          if (idx_q == IW'(UART_DATA_LENGTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = stPARITY;
`else
            state_d = stSTOPBIT;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      stPARITY: begin
        tx_d = par_q;
        if (bit_end) state_d = stSTOPBIT;
      end
`endif
      stSTOPBIT: begin
        tx_d = 1'b1;
        if (bit_end) begin
          done_d = 1'b1;
          // Chain straight into the next frame when a word is waiting.
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            idx_d       = '0;
`ifdef UART_TX_PARITY_EN
            par_d       = 1'b0;
`endif
            state_d     = stSTARTBIT;
          end else begin
            state_d = stIDLE;
          end
        end
      end
      default: state_d = stIDLE;
    endcase
  end

  assign tx_o           = tx_q;
  assign done_strb_o    = done_q;
  assign busy_o         = (state_q != stIDLE) || hold_full_q;
  assign bus_if.ready_o = !hold_full_q;

endmodule
